// File: rtl/operand_collector_pkg.sv
// operand_collector_pkg: opcode, collector state and read-tag types shared by the collector
package operand_collector_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_MAD, OP_SHFTL, OP_SHFTR, OP_AND, OP_OR, OP_XOR
  } alu_op_t;
  typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_B, S_RD_C, S_DRAIN, S_ISSUE} oc_state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_A, TAG_B, TAG_C} oc_tag_t;
  function automatic logic is_mad(input logic [3:0] op);
    return op == OP_MAD;
  endfunction
endpackage

// File: rtl/operand_collector_fwd.sv
// oc_fwd: picks same-cycle writeback data over an operand value when its register matches
module oc_fwd #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  assign dout = (wb_valid && wb_addr == addr) ? wb_data : din;
endmodule

// File: rtl/operand_collector.sv
// operand_collector: reads sources one per cycle, forwards writebacks, issues the ALU bundle
module operand_collector
  import operand_collector_pkg::*;
#(
  parameter int REGS   = 32,
  parameter int ADDR_W = $clog2(REGS),
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rs_a,
  input  logic [ADDR_W-1:0] in_rs_b,
  input  logic [ADDR_W-1:0] in_rs_c,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_c,
  output logic [3:0]        out_op,
  output logic [ADDR_W-1:0] out_rd
);
  oc_state_t state, nxt;
  oc_tag_t tag, tag_nxt;
  logic [ADDR_W-1:0] tag_addr, rs_a, rs_b, rs_c;
  logic use_imm, have_a, have_b, have_c, accept, run, mad;
  logic [DATA_W-1:0] rd_fwd, a_fwd, b_fwd, c_fwd;
  assign mad = is_mad(out_op);
  assign in_ready = state == S_IDLE;
  assign out_valid = state == S_ISSUE;
  assign accept = in_valid && in_ready && !flush;
  assign run = state != S_IDLE && !flush;
  assign rf_rd_en = state == S_RD_A || state == S_RD_B || state == S_RD_C;
  assign rf_rd_addr = state == S_RD_A ? rs_a : state == S_RD_B ? rs_b : state == S_RD_C ? rs_c : '0;
  always_comb begin
    nxt = state;
    tag_nxt = TAG_NONE;
    case (state)
      S_IDLE:  nxt = in_valid ? S_RD_A : S_IDLE;
      S_RD_A: begin
        tag_nxt = TAG_A;
        nxt = !use_imm ? S_RD_B : mad ? S_RD_C : S_DRAIN;
      end
      S_RD_B: begin
        tag_nxt = TAG_B;
        nxt = mad ? S_RD_C : S_DRAIN;
      end
      S_RD_C: begin
        tag_nxt = TAG_C;
        nxt = S_DRAIN;
      end
      S_DRAIN: nxt = S_ISSUE;
      S_ISSUE: nxt = out_ready ? S_IDLE : S_ISSUE;
      default: nxt = S_IDLE;
    endcase
    if (flush) begin
      nxt = S_IDLE;
      tag_nxt = TAG_NONE;
    end
  end
  oc_fwd #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd_rd (.wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .addr(tag_addr), .din(rf_rd_data), .dout(rd_fwd));
  oc_fwd #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd_a (.wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .addr(rs_a), .din(out_a), .dout(a_fwd));
  oc_fwd #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd_b (.wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .addr(rs_b), .din(out_b), .dout(b_fwd));
  oc_fwd #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd_c (.wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .addr(rs_c), .din(out_c), .dout(c_fwd));
  // have_* marks operands already captured from a register; only those track later writebacks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      tag <= TAG_NONE;
      tag_addr <= '0;
      rs_a <= '0;
      rs_b <= '0;
      rs_c <= '0;
      use_imm <= 1'b0;
      have_a <= 1'b0;
      have_b <= 1'b0;
      have_c <= 1'b0;
      out_a <= '0;
      out_b <= '0;
      out_c <= '0;
      out_op <= '0;
      out_rd <= '0;
    end else begin
      state <= nxt;
      tag <= tag_nxt;
      tag_addr <= rf_rd_addr;
      if (accept) begin
        rs_a <= in_rs_a;
        rs_b <= in_rs_b;
        rs_c <= in_rs_c;
        use_imm <= in_use_imm;
        out_op <= in_op;
        out_rd <= in_rd;
        out_a <= '0;
        out_b <= in_use_imm ? in_imm : '0;
        out_c <= '0;
        have_a <= 1'b0;
        have_b <= 1'b0;
        have_c <= 1'b0;
      end else if (run) begin
        out_a <= tag == TAG_A ? rd_fwd : have_a ? a_fwd : out_a;
        out_b <= tag == TAG_B ? rd_fwd : have_b ? b_fwd : out_b;
        out_c <= tag == TAG_C ? rd_fwd : have_c ? c_fwd : out_c;
        have_a <= have_a || tag == TAG_A;
        have_b <= have_b || tag == TAG_B;
        have_c <= have_c || tag == TAG_C;
      end
    end
  end
endmodule
